regfile_dump_reader: RTL and testbench



---
 rtl/regfile_dump_reader.sv | 134 +++++++++++++
 tb/tb_regfile_dump_reader.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_reader
// Purpose  : Walks registers FIRST_REG..LAST_REG through one read port and
//            streams (index, data) snapshots over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_reader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [ADDR_W-1:0] C_FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] C_LAST_IDX  = ADDR_W'(LAST_REG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] out_index_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [ADDR_W-1:0] cnt_d;
  logic              last_d;
  logic              xfer_d;

  assign cnt_d  = cnt_q + ADDR_W'(1);
  assign last_d = (cnt_q == C_LAST_IDX);
  assign xfer_d = out_valid_q & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= C_FIRST_IDX;
      rd_addr_q   <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // abort takes priority over a simultaneous start
          if (start && !abort) begin
            state_q   <= S_READ;
            busy_q    <= 1'b1;
            cnt_q     <= C_FIRST_IDX;
            rd_addr_q <= C_FIRST_IDX;
          end
        end
        S_READ: begin
          if (abort) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= C_FIRST_IDX;
            rd_addr_q <= '0;
          end else begin
            out_data_q  <= rf_read_data;
            out_index_q <= cnt_q;
            out_valid_q <= 1'b1;
            rd_addr_q   <= '0;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (abort) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= C_FIRST_IDX;
          end else if (xfer_d) begin
            out_valid_q <= 1'b0;
            // LAST_REG is terminal, so the counter never wraps
            if (last_d) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              cnt_q     <= cnt_d;
              rd_addr_q <= cnt_d;
              state_q   <= S_READ;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= C_FIRST_IDX;
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          cnt_q       <= C_FIRST_IDX;
          rd_addr_q   <= '0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign rf_read_addr = rd_addr_q;
  assign out_valid    = out_valid_q;
  assign out_index    = out_index_q;
  assign out_data     = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// Bench for regfile_dump_reader: register-file model, scoreboard of expected
// (index, data) words built from the register contents at dump start.
module tb_regfile_dump_reader;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst, start, abort, out_ready;
  logic busy, done, out_valid;
  logic [AW-1:0] rf_read_addr, out_index;
  logic [DW-1:0] rf_read_data, out_data;

  logic start1, abort1, out_ready1;
  logic busy1, done1, out_valid1;
  logic [AW-1:0] rf_read_addr1, out_index1;
  logic [DW-1:0] rf_read_data1, out_data1;

  logic [DW-1:0] rf [32];

  always #5 clk = ~clk;

  // x0 reads as zero regardless of the array contents
  assign rf_read_data  = (rf_read_addr == '0)  ? '0 : rf[rf_read_addr];
  assign rf_read_data1 = (rf_read_addr1 == '0) ? '0 : rf[rf_read_addr1];

  regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(0), .LAST_REG(31)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index), .out_data(out_data)
  );

  regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(31), .LAST_REG(31)) u_one (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
    .rf_read_addr(rf_read_addr1), .rf_read_data(rf_read_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_index(out_index1), .out_data(out_data1)
  );

  int checks = 0;
  int failures = 0;
  logic [AW-1:0] got_idx [$];
  logic [DW-1:0] got_dat [$];
  logic [AW-1:0] exp_idx [$];
  logic [DW-1:0] exp_dat [$];
  int done_cnt, done_cyc, busy_fall, unstable, overlap;

  task automatic preload();
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[0] = 32'hDEAD_BEEF;
    rf[1] = 32'd10;
    rf[2] = 32'd10;
    rf[9] = 32'h0000_FFFF;
  endtask

  task automatic build_expected(input int first, input int last);
    exp_idx.delete();
    exp_dat.delete();
    for (int i = first; i <= last; i++) begin
      exp_idx.push_back(AW'(i));
      exp_dat.push_back((i == 0) ? 32'd0 : rf[i]);
    end
  endtask

  task automatic run_dump(input int ready_pct, input int poke_idx, input int wr_idx,
                          input logic [DW-1:0] wr_val);
    logic pv, pr;
    logic [AW-1:0] pi;
    logic [DW-1:0] pd;
    bit wrote, poked;
    got_idx.delete();
    got_dat.delete();
    done_cnt = 0; done_cyc = -1; busy_fall = -1; unstable = 0; overlap = 0;
    pv = 1'b0; pr = 1'b0; pi = '0; pd = '0; wrote = 0; poked = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k <= 1000; k++) begin
      if (k > 0) @(negedge clk);
      start = 1'b0;
      if (done) begin done_cnt++; done_cyc = k; end
      if (done && out_valid) overlap++;
      if (!busy) begin busy_fall = k; break; end
      if (pv && !pr && (!out_valid || out_index !== pi || out_data !== pd)) unstable++;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (out_valid && int'(out_index) == wr_idx && !wrote) begin
        rf[wr_idx] = wr_val;
        out_ready = 1'b0;
        wrote = 1;
      end
      if (out_valid && int'(out_index) == poke_idx && !poked) begin
        start = 1'b1;
        poked = 1;
      end
      if (out_valid && out_ready) begin
        got_idx.push_back(out_index);
        got_dat.push_back(out_data);
      end
      pv = out_valid; pr = out_ready; pi = out_index; pd = out_data;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, out_valid, busy1, done1, out_valid1} !== 6'b0 || out_index !== '0 ||
        out_data !== '0 || rf_read_addr !== '0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b valid=%b idx=%0d data=%h addr=%0d required all zero",
               busy, done, out_valid, out_index, out_data, rf_read_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_dump();
    preload();
    build_expected(0, 31);
    run_dump(100, -1, -1, '0);
    checks++;
    if (got_idx.size() != exp_idx.size()) begin
      failures++;
      $display("FAIL full_count got=%0d required=%0d", got_idx.size(), exp_idx.size());
    end
    for (int i = 0; i < exp_idx.size() && i < got_idx.size(); i++) begin
      checks++;
      if (got_idx[i] !== exp_idx[i] || got_dat[i] !== exp_dat[i]) begin
        failures++;
        $display("FAIL full_word[%0d] got=(%0d,%h) required=(%0d,%h)", i, got_idx[i], got_dat[i],
                 exp_idx[i], exp_dat[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 64) begin
      failures++;
      $display("FAIL full_done pulses=%0d at=%0d required 1 at 64", done_cnt, done_cyc);
    end
    checks++;
    if (busy_fall != 65 || overlap != 0) begin
      failures++;
      $display("FAIL full_busy_fall at=%0d overlap=%0d required 65 and 0", busy_fall, overlap);
    end
  endtask

  task automatic test_random_ready();
    preload();
    build_expected(0, 31);
    run_dump(30, -1, -1, '0);
    checks++;
    if (got_idx.size() != exp_idx.size() || busy_fall < 0) begin
      failures++;
      $display("FAIL rand_count got=%0d required=%0d busy_fall=%0d", got_idx.size(), exp_idx.size(),
               busy_fall);
    end
    for (int i = 0; i < exp_idx.size() && i < got_idx.size(); i++) begin
      checks++;
      if (got_idx[i] !== exp_idx[i] || got_dat[i] !== exp_dat[i]) begin
        failures++;
        $display("FAIL rand_word[%0d] got=(%0d,%h) required=(%0d,%h)", i, got_idx[i], got_dat[i],
                 exp_idx[i], exp_dat[i]);
      end
    end
    checks++;
    if (unstable != 0 || done_cnt != 1 || overlap != 0) begin
      failures++;
      $display("FAIL rand_stable unstable=%0d done=%0d overlap=%0d required 0,1,0", unstable,
               done_cnt, overlap);
    end
  endtask

  task automatic test_snapshot();
    preload();
    build_expected(0, 31);
    run_dump(100, -1, 9, 32'h1234_5678);
    checks++;
    if (got_idx.size() != 32 || got_dat[9] !== 32'h0000_FFFF || got_idx[9] !== 5'd9) begin
      failures++;
      $display("FAIL snap_held got_count=%0d data9=%h required 32 and 0000ffff", got_idx.size(),
               (got_dat.size() > 9) ? got_dat[9] : 32'hx);
    end
    build_expected(0, 31);
    run_dump(100, -1, -1, '0);
    checks++;
    if (got_idx.size() != 32 || got_dat[9] !== 32'h1234_5678) begin
      failures++;
      $display("FAIL snap_second got_count=%0d data9=%h required 32 and 12345678", got_idx.size(),
               (got_dat.size() > 9) ? got_dat[9] : 32'hx);
    end
  endtask

  task automatic test_abort();
    bit reached;
    int seen_done;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_beats_start busy=%b required 0", busy);
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    reached = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (out_valid && out_index == 5'd5) begin
        out_ready = 1'b0; abort = 1'b1; reached = 1;
        break;
      end
      out_ready = 1'b1;
    end
    @(negedge clk); abort = 1'b0;
    checks++;
    if (!reached || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_hold reached=%0d valid=%b busy=%b required 1,0,0", reached, out_valid, busy);
    end
    seen_done = 0;
    for (int k = 0; k < 4; k++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL abort_no_done pulses=%0d required 0", seen_done);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 5 && !out_valid; k++) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_index !== 5'd0) begin
      failures++;
      $display("FAIL abort_restart valid=%b idx=%0d required 1 and 0", out_valid, out_index);
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_restart_ignored();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    build_expected(0, 31);
    run_dump(100, 12, -1, '0);
    checks++;
    if (got_idx.size() != 32 || done_cnt != 1 || done_cyc != 64) begin
      failures++;
      $display("FAIL restart_ignored count=%0d done=%0d at=%0d required 32,1,64", got_idx.size(),
               done_cnt, done_cyc);
    end
    for (int i = 0; i < exp_idx.size() && i < got_idx.size(); i++) begin
      checks++;
      if (got_idx[i] !== exp_idx[i] || got_dat[i] !== exp_dat[i]) begin
        failures++;
        $display("FAIL restart_word[%0d] got=(%0d,%h) required=(%0d,%h)", i, got_idx[i],
                 got_dat[i], exp_idx[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    bit reached;
    int seen_done;
    preload();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    reached = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (out_valid && out_index == 5'd2) begin
        out_ready = 1'b0; reached = 1;
        break;
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!reached || out_valid !== 1'b0 || busy !== 1'b0 || out_index !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL async_reset reached=%0d valid=%b busy=%b idx=%0d data=%h required 1,0,0,0,0",
               reached, out_valid, busy, out_index, out_data);
    end
    @(negedge clk); rst = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL async_reset_quiet done_or_busy=%0d required 0", seen_done);
    end
  endtask

  task automatic test_single();
    int words, dones;
    logic [AW-1:0] widx;
    logic [DW-1:0] wdat, exp31;
    rf[31] = $urandom;
    exp31 = rf[31];
    words = 0; dones = 0; widx = '0; wdat = '0;
    out_ready1 = 1'b1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (done1) dones++;
      if (out_valid1 && out_ready1) begin words++; widx = out_index1; wdat = out_data1; end
    end
    out_ready1 = 1'b0;
    checks++;
    if (words != 1 || widx !== 5'd31 || wdat !== exp31) begin
      failures++;
      $display("FAIL single_word count=%0d idx=%0d data=%h required 1,31,%h", words, widx, wdat, exp31);
    end
    checks++;
    if (dones != 1 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL single_done pulses=%0d busy=%b required 1 and 0", dones, busy1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; out_ready1 = 1'b0;
    preload();
    test_reset();
    test_full_dump();
    test_random_ready();
    test_snapshot();
    test_abort();
    test_restart_ignored();
    test_async_reset();
    test_single();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
